// File: rtl/imsic_msi_tx_pkg.sv
// Shared types and width helpers for the IMSIC MSI-info link.
// The info word is {hart, file, eiid}, MSB to LSB; the receiver uses the same offsets.
package imsic_msi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_HOLD = 2'd2
  } tx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int hart_width(input int nr_harts);
    return (nr_harts > 32'sd1) ? $clog2(nr_harts) : 32'sd1;
  endfunction

  function automatic int info_width(input int nr_harts, input int nr_files, input int nr_src);
    return hart_width(nr_harts) + $clog2(nr_files) + $clog2(nr_src);
  endfunction

  // A single down-counter times both the strobe and the hold window.
  function automatic int cnt_width(input int vld_high_cyc, input int hold_cyc);
    return $clog2(max_int(vld_high_cyc, hold_cyc)) + 32'sd1;
  endfunction

  function automatic int eiid_lsb();
    return 32'sd0;
  endfunction

  function automatic int file_lsb(input int nr_src);
    return $clog2(nr_src);
  endfunction

  function automatic int hart_lsb(input int nr_files, input int nr_src);
    return $clog2(nr_src) + $clog2(nr_files);
  endfunction

endpackage

// File: rtl/imsic_msi_tx_fifo.sv
// Synchronous request FIFO with extra-MSB pointers; push and pop may share a cycle,
// and a push while full is taken only when the same cycle also pops.
module imsic_msi_tx_fifo
  import imsic_msi_tx_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign wr_en_s = push & (~full_s | pop);
  assign rd_en_s = pop & ~empty_s;

  assign full  = full_s;
  assign empty = empty_s;
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array: cleared on reset so a stale entry can never be replayed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // Read/write pointers wrap naturally through their extra MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/imsic_msi_tx.sv
// IMSIC MSI-info transmitter: filters illegal requests, queues legal ones and sends each
// as a vld pulse followed by a hold window so the receiver can capture on vld's fall.
module imsic_msi_tx
  import imsic_msi_tx_pkg::*;
#(
  parameter  int NR_INTP_FILES   = 7,
  parameter  int NR_HARTS        = 4,
  parameter  int NR_SRC          = 32,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int VLD_HIGH_CYC    = 4,
  parameter  int HOLD_CYC        = 6,
  localparam int NR_HARTS_WIDTH  = hart_width(NR_HARTS),
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_req_vld,
  output logic                       o_req_rdy,
  input  logic [NR_HARTS_WIDTH-1:0]  i_req_hart,
  input  logic [INTP_FILE_WIDTH-1:0] i_req_file,
  input  logic [NR_SRC_WIDTH-1:0]    i_req_eiid,
  output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
  output logic                       o_msi_info_vld,
  output logic                       o_drop,
  output logic                       o_busy
);

  localparam int CNT_W = cnt_width(VLD_HIGH_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(VLD_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  tx_state_e                 state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [MSI_INFO_WIDTH-1:0] info_r;
  logic                      vld_r;
  logic                      drop_r;

  logic                      hart_ok_s;
  logic                      file_ok_s;
  logic                      src_ok_s;
  logic                      legal_s;
  logic                      accept_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [MSI_INFO_WIDTH-1:0] req_info_s;
  logic [MSI_INFO_WIDTH-1:0] fifo_dout_s;

  // Range checks are only built where the field can encode out-of-range values.
  if ((1 << NR_HARTS_WIDTH) > NR_HARTS) begin : g_hart_chk
    assign hart_ok_s = (i_req_hart < NR_HARTS_WIDTH'(NR_HARTS));
  end else begin : g_hart_all
    assign hart_ok_s = 1'b1;
  end

  if ((1 << INTP_FILE_WIDTH) > NR_INTP_FILES) begin : g_file_chk
    assign file_ok_s = (i_req_file < INTP_FILE_WIDTH'(NR_INTP_FILES));
  end else begin : g_file_all
    assign file_ok_s = 1'b1;
  end

  if ((1 << NR_SRC_WIDTH) > NR_SRC) begin : g_src_chk
    assign src_ok_s = (i_req_eiid < NR_SRC_WIDTH'(NR_SRC));
  end else begin : g_src_all
    assign src_ok_s = 1'b1;
  end

  assign legal_s    = (i_req_eiid != {NR_SRC_WIDTH{1'b0}}) & src_ok_s & file_ok_s & hart_ok_s;
  assign o_req_rdy  = ~fifo_full_s;
  assign accept_s   = i_req_vld & ~fifo_full_s;
  assign push_s     = accept_s & legal_s;
  assign req_info_s = {i_req_hart, i_req_file, i_req_eiid};

  imsic_msi_tx_fifo #(
    .WIDTH (MSI_INFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .din   (req_info_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Pop the head when idle, or at hold expiry for a back-to-back message.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = ~fifo_empty_s;
      ST_HOLD: pop_s = ~fifo_empty_s & (cnt_r == CNT_ZERO);
      default: pop_s = 1'b0;
    endcase
  end

  // Message sequencer: strobe window, hold window, and the registered info/vld outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      info_r  <= {MSI_INFO_WIDTH{1'b0}};
      vld_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            info_r  <= fifo_dout_s;
            vld_r   <= 1'b1;
            cnt_r   <= HIGH_LOAD;
            state_r <= ST_HIGH;
          end else begin
            vld_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (cnt_r == CNT_ZERO) begin
            vld_r   <= 1'b0;
            cnt_r   <= HOLD_LOAD;
            state_r <= ST_HOLD;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r   <= cnt_r - CNT_ONE;
          end else if (pop_s) begin
            info_r  <= fifo_dout_s;
            vld_r   <= 1'b1;
            cnt_r   <= HIGH_LOAD;
            state_r <= ST_HIGH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          vld_r   <= 1'b0;
          cnt_r   <= CNT_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Drop strobe: one cycle after an illegal request is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= accept_s & ~legal_s;
    end
  end

  assign o_msi_info     = info_r;
  assign o_msi_info_vld = vld_r;
  assign o_drop         = drop_r;
  assign o_busy         = (state_r != ST_IDLE) | ~fifo_empty_s;

endmodule
